mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Multicycle control FSM for the MIPS Lite datapath. It sequences one shared ALU, one unified instruction/data memory and the register file over 3–5 cycles per instruction for R-type, LW, SW, BEQ, ADDI and J. It decodes the opcode in the DECODE state, stalls on a memory ready handshake and aborts memory accesses that time out. It sits beside the multicycle datapath and replaces the single-cycle main decoder; the funct field is still decoded by the existing ALU decoder from aluop.

Parameters:
MEM_TIMEOUT, 16, number of consecutive not-ready cycles in a memory state before abort; 0 disables the timeout.
TMO_W, 5, width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
op  in  6  opcode field from the instruction register.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access requested.
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
memwrite  out  1  memory write strobe.
irwrite  out  1  instruction register load.
pcen  out  1  PC load; equals pcwrite | (branch & zero).
regwrite  out  1  register file write.
regdst  out  1  destination register: 1 = rd, 0 = rt.
memtoreg  out  1  write-back source: 1 = memory data, 0 = ALUOut.
alusrca  out  1  ALU A input: 0 = PC, 1 = register A.
alusrcb  out  2  ALU B input: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
aluop  out  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = funct.
pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
instr_done  out  1  one-cycle pulse when an instruction retires.
illegal_op  out  1  one-cycle pulse when an unknown opcode is decoded.
mem_err  out  1  one-cycle pulse when a memory access times out.

Behaviour:
- Outputs are Moore outputs decoded from the state. Exception: in memory states, irwrite, pcwrite and memwrite are ANDed with mem_ready. Any output not listed for a state is 0.
- Reset (reset = 0): state = FETCH, timeout counter = 0. All enables and pulses are forced to 0 combinationally and all selects are 0. This holds when reset is asserted mid-instruction; partial writes never complete.
- FETCH: mem_req=1, iord=0, alusrcb=01, irwrite=pcwrite=mem_ready. On mem_ready go to DECODE, otherwise stay.
- DECODE: alusrcb=11. Next state by op:
  - 100011 / 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op -> FETCH, with illegal_op=1.
- MEMADR: alusrca=1, alusrcb=10. Go to MEMRD if op = LW, otherwise MEMWR.
- MEMRD: mem_req=1, iord=1. On mem_ready go to MEMWB.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1. Then FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=mem_ready. On mem_ready: instr_done=1, go to FETCH.
- EXECUTE: alusrca=1, aluop=10. Then ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1. Then FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1, instr_done=1. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Then ADDIWB.
- ADDIWB: regwrite=1, instr_done=1. Then FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1. Then FETCH.
- Cycle counts with zero wait states: LW 5; SW, R-type and ADDI 4; BEQ and J 3.
- Timeout counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on any state change and whenever mem_ready=1.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT-1 while mem_ready=0: mem_err=1, next state FETCH, no write enable asserted, PC unchanged (FETCH retries the same PC).
  - mem_ready=1 in the same cycle as the timeout wins: the access completes normally.
- Reserved state encodings go to FETCH.

Optional Feature:
MC_PERF_CNT_EN
- Defined: adds output retired_cnt[31:0] and cycle_cnt[31:0]. Both reset to 0. retired_cnt increments on instr_done; cycle_cnt increments every cycle out of reset. Both wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - state enum, 4 bits;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - alusrcb, pcsrc and aluop encodings.
- No sub-module: the FSM with its output decode and the timeout counter form one block. The existing ALU decoder stays separate.

Test Plan:
- LW with op=100011, mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 in cycle 5; instr_done high in cycle 5 only.
- BEQ with zero=1, then again with zero=0 -> pcen=1 in BEQ cycle 3 for zero=1, pcen=0 for zero=0; both return to FETCH in cycle 4.
- SW with mem_ready low for 3 cycles in MEMWR -> memwrite stays 0 until mem_ready=1; SW totals 7 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> mem_err pulses on the 4th stall cycle; irwrite and pcen are never 1; state returns to FETCH.
- op=111111 -> illegal_op pulses in DECODE; next state FETCH; regwrite, memwrite and pcen stay 0.
- reset driven low during ADDIEX -> all outputs 0 immediately; after release, fetch restarts with no regwrite issued.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and control-select encodings for the multicycle controller
package mc_pkg;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;
   localparam logic [1:0] PCSRC_ALU = 2'b00;
   localparam logic [1:0] PCSRC_OUT = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> datapath/memory control bundle
interface mc_controller_if;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       pcen;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsrc;
   logic       instr_done;
   logic       illegal_op;
   logic       mem_err;
   modport master (
      input  op, zero, mem_ready,
      output mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
             alusrca, alusrcb, aluop, pcsrc, instr_done, illegal_op, mem_err
   );
   modport slave (
      output op, zero, mem_ready,
      input  mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
             alusrca, alusrcb, aluop, pcsrc, instr_done, illegal_op, mem_err
   );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS Lite control FSM with memory timeout; MC_PERF_CNT_EN adds retired/cycle counters
module mc_controller
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 5
) (
   input  logic clk,
   input  logic reset,
   mc_controller_if.master bus
`ifdef MC_PERF_CNT_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [31:0] cycle_cnt
`endif
);
   state_t state, next;
   logic [TMO_W-1:0] tmo;
   logic mem_state, timeout, pcwrite, branch;
   assign mem_state = state inside {FETCH, MEMRD, MEMWR};
   assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready && (tmo == TMO_W'(MEM_TIMEOUT - 1));
   // state register and stall counter; the counter only survives consecutive stalled cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         tmo   <= '0;
      end else begin
         state <= next;
         tmo   <= (mem_state && !bus.mem_ready && !timeout) ? tmo + 1'b1 : '0;
      end
   end
   // next state and Moore outputs; everything stays 0 while reset is asserted
   always_comb begin
      next           = state;
      pcwrite        = 1'b0;
      branch         = 1'b0;
      bus.mem_req    = 1'b0;
      bus.iord       = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regwrite   = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = SRCB_REG;
      bus.aluop      = ALUOP_ADD;
      bus.pcsrc      = PCSRC_ALU;
      bus.instr_done = 1'b0;
      bus.illegal_op = 1'b0;
      bus.mem_err    = reset && timeout;
      if (reset) begin
         case (state)
            FETCH: begin
               bus.mem_req = 1'b1;
               bus.alusrcb = SRCB_FOUR;
               bus.irwrite = bus.mem_ready;
               pcwrite     = bus.mem_ready;
               next        = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               bus.alusrcb = SRCB_IMMSH;
               case (bus.op)
                  OP_LW, OP_SW: next = MEMADR;
                  OP_RTYPE:     next = EXECUTE;
                  OP_BEQ:       next = BRANCH;
                  OP_ADDI:      next = ADDIEX;
                  OP_J:         next = JUMP;
                  default: begin
                     next           = FETCH;
                     bus.illegal_op = 1'b1;
                  end
               endcase
            end
            MEMADR: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
               next        = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
               bus.mem_req = 1'b1;
               bus.iord    = 1'b1;
               next        = bus.mem_ready ? MEMWB : timeout ? FETCH : MEMRD;
            end
            MEMWB: begin
               bus.memtoreg   = 1'b1;
               bus.regwrite   = 1'b1;
               bus.instr_done = 1'b1;
               next           = FETCH;
            end
            MEMWR: begin
               bus.mem_req    = 1'b1;
               bus.iord       = 1'b1;
               bus.memwrite   = bus.mem_ready;
               bus.instr_done = bus.mem_ready;
               next           = (bus.mem_ready || timeout) ? FETCH : MEMWR;
            end
            EXECUTE: begin
               bus.alusrca = 1'b1;
               bus.aluop   = ALUOP_FUNCT;
               next        = ALUWB;
            end
            ALUWB: begin
               bus.regdst     = 1'b1;
               bus.regwrite   = 1'b1;
               bus.instr_done = 1'b1;
               next           = FETCH;
            end
            BRANCH: begin
               bus.alusrca    = 1'b1;
               bus.aluop      = ALUOP_SUB;
               bus.pcsrc      = PCSRC_OUT;
               branch         = 1'b1;
               bus.instr_done = 1'b1;
               next           = FETCH;
            end
            ADDIEX: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
               next        = ADDIWB;
            end
            ADDIWB: begin
               bus.regwrite   = 1'b1;
               bus.instr_done = 1'b1;
               next           = FETCH;
            end
            JUMP: begin
               bus.pcsrc      = PCSRC_JMP;
               pcwrite        = 1'b1;
               bus.instr_done = 1'b1;
               next           = FETCH;
            end
            default: next = FETCH;
         endcase
      end
      bus.pcen = pcwrite | (branch & bus.zero);
   end
`ifdef MC_PERF_CNT_EN
   // retired-instruction and free-running cycle counters, both wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_cnt <= '0;
         cycle_cnt   <= '0;
      end else begin
         retired_cnt <= retired_cnt + {31'd0, bus.instr_done};
         cycle_cnt   <= cycle_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed and random checks of mc_controller against a step-queue reference model
module tb_mc_controller;
   import mc_pkg::*;
   localparam int TMO = 4;
   typedef enum {F, D, MA, MR, MWB, MW, EX, AWB, BR, AEX, IWB, JP} step_t;
   typedef struct packed {
      logic mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
      logic [1:0] alusrcb, aluop, pcsrc;
      logic instr_done, illegal_op, mem_err;
   } outs_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int total = 0;
   int bad = 0;
   int retired = 0;
   step_t cur = F;
   step_t rest[$];
   int stall = 0;
   mc_controller_if bus();
`ifdef MC_PERF_CNT_EN
   logic [31:0] retired_cnt, cycle_cnt;
`endif
   mc_controller #(.MEM_TIMEOUT(TMO), .TMO_W(5)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef MC_PERF_CNT_EN
      , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
   );
   always #5 clk = ~clk;

   function automatic outs_t sample();
      return {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite, bus.regdst,
              bus.memtoreg, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.instr_done,
              bus.illegal_op, bus.mem_err};
   endfunction

   // what the datapath should see for one step of an instruction
   function automatic outs_t model_out(step_t s, logic [5:0] op, logic z, logic r, int st);
      outs_t e = '0;
      logic hit = !r && (st == TMO - 1);
      case (s)
         F:   begin e.mem_req = 1; e.alusrcb = 2'd1; e.irwrite = r; e.pcen = r; e.mem_err = hit; end
         D:   begin e.alusrcb = 2'd3; e.illegal_op = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}); end
         MA:  begin e.alusrca = 1; e.alusrcb = 2'd2; end
         MR:  begin e.mem_req = 1; e.iord = 1; e.mem_err = hit; end
         MWB: begin e.memtoreg = 1; e.regwrite = 1; e.instr_done = 1; end
         MW:  begin e.mem_req = 1; e.iord = 1; e.memwrite = r; e.instr_done = r; e.mem_err = hit; end
         EX:  begin e.alusrca = 1; e.aluop = 2'd2; end
         AWB: begin e.regdst = 1; e.regwrite = 1; e.instr_done = 1; end
         BR:  begin e.alusrca = 1; e.aluop = 2'd1; e.pcsrc = 2'd1; e.pcen = z; e.instr_done = 1; end
         AEX: begin e.alusrca = 1; e.alusrcb = 2'd2; end
         IWB: begin e.regwrite = 1; e.instr_done = 1; end
         JP:  begin e.pcsrc = 2'd2; e.pcen = 1; e.instr_done = 1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // move the model to the step that follows this cycle
   task automatic advance(input logic r);
      if (cur inside {F, MR, MW} && !r) begin
         if (stall == TMO - 1) begin
            cur = F;
            rest.delete();
            stall = 0;
         end else stall++;
      end else begin
         stall = 0;
         if (cur == F) cur = D;
         else begin
            if (cur == D)
               case (bus.op)
                  OP_LW:    rest = '{MA, MR, MWB};
                  OP_SW:    rest = '{MA, MW};
                  OP_RTYPE: rest = '{EX, AWB};
                  OP_BEQ:   rest = '{BR};
                  OP_ADDI:  rest = '{AEX, IWB};
                  OP_J:     rest = '{JP};
                  default:  rest.delete();
               endcase
            cur = (rest.size() != 0) ? rest.pop_front() : F;
         end
      end
   endtask

   task automatic cyc(input logic r, output outs_t o, output outs_t e);
      bus.mem_ready = r;
      @(negedge clk);
      e = model_out(cur, bus.op, bus.zero, r, stall);
      o = sample();
      chk("cycle_outputs", 32'(o), 32'(e));
      if (e.instr_done) retired++;
      @(posedge clk);
      advance(r);
      #1;
   endtask

   task automatic run(input logic [5:0] opv, input logic z, input logic [31:0] nrdy, output int n, output outs_t last);
      outs_t o, e;
      bus.op = opv;
      bus.zero = z;
      n = 0;
      last = '0;
      for (int i = 0; i < 32; i++) begin
         cyc(!nrdy[i], o, e);
         if (e.instr_done || e.illegal_op || e.mem_err) begin
            n = i + 1;
            last = o;
            break;
         end
      end
      if (n == 0) begin
         total++;
         bad++;
         $error("FAIL run_bound observed=no_end expected=end_within_32");
      end
   endtask

   initial begin
      int n;
      outs_t last, o, e;
      logic [5:0] pool[7] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'h3F};
      bus.op = OP_RTYPE;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      chk("reset_outputs", 32'(sample()), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      run(OP_LW, 0, 32'h0, n, last);
      chk("lw_cycles", n, 5);
      chk("lw_wb", {last.regwrite, last.memtoreg}, 2'b11);
      run(OP_BEQ, 1, 32'h0, n, last);
      chk("beq_taken_cycles", n, 3);
      chk("beq_taken_pcen", last.pcen, 1);
      run(OP_BEQ, 0, 32'h0, n, last);
      chk("beq_not_taken_pcen", last.pcen, 0);
      chk("beq_returns_fetch", cur == F, 1);
      run(OP_SW, 0, 32'h38, n, last);
      chk("sw_stall_cycles", n, 7);
      chk("sw_memwrite", last.memwrite, 1);
      run(OP_RTYPE, 0, 32'h0, n, last);
      chk("rtype_cycles", n, 4);
      run(OP_ADDI, 0, 32'h0, n, last);
      chk("addi_cycles", n, 4);
      run(OP_J, 0, 32'h0, n, last);
      chk("j_cycles", n, 3);
      run(OP_LW, 0, 32'hF, n, last);
      chk("fetch_timeout_cycle", n, 4);
      chk("fetch_timeout_err", last.mem_err, 1);
      run(OP_LW, 0, 32'h78, n, last);
      chk("memrd_timeout_cycle", n, 7);
      chk("memrd_timeout_err", {last.mem_err, last.regwrite}, 2'b10);
      run(OP_LW, 0, 32'h38, n, last);
      chk("memrd_ready_at_limit", n, 8);
      run(6'h3F, 0, 32'h0, n, last);
      chk("illegal_cycles", n, 2);
      chk("illegal_pulse", {last.illegal_op, last.regwrite, last.memwrite, last.pcen}, 4'b1000);
      bus.op = OP_ADDI;
      cyc(1, o, e);
      cyc(1, o, e);
      reset = 1'b0;
      #1;
      chk("reset_in_addiex", 32'(sample()), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cur = F;
      rest.delete();
      stall = 0;
      run(OP_ADDI, 0, 32'h0, n, last);
      chk("addi_after_reset", n, 4);
      for (int k = 0; k < 300; k++)
         run(pool[$urandom_range(0, 6)], 1'($urandom), $urandom & $urandom & $urandom, n, last);
`ifdef MC_PERF_CNT_EN
      chk("retired_cnt", retired_cnt, 32'(retired));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
